seg_display_capture: RTL and testbench

- Receive-side counterpart of the multiplexed 6-digit 7-segment display driver.
- Samples the SEG/ENABLE pins and reconstructs the six displayed BCD digits (HH:MM:SS).
- Reports the full displayed time once every digit position has been captured.
- Used as an on-chip display self-check and as the bench monitor for the clock design.

---
 rtl/seg_display_capture.sv | 194 +++++++++++++++++++
 tb/tb_seg_display_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_capture.sv
// Receive side of the multiplexed 6-digit 7-segment display: samples SEG/ENABLE,
// debounces each digit dwell, decodes the glyph and reports complete HH:MM:SS frames.
module seg_display_capture #(
  parameter int STABLE_CYCLES  = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit EN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg_in,
  input  logic [5:0]  enable_in,
  output logic [23:0] time_bcd,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        digit_update,
  output logic [2:0]  digit_index,
  output logic [5:0]  dp_flags,
  output logic        seg_error,
  output logic        enable_error
);

  localparam logic [15:0] STABLE = 16'(STABLE_CYCLES);

  // Input sample registers hold pin levels already normalised to active-high,
  // so their cleared state reads as "blank" rather than "all enables on".
  logic [7:0]       seg_s_q, seg_s_d;
  logic [5:0]       en_s_q, en_s_d;

  logic [15:0]      cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             prev_valid_q, prev_valid_d;
  logic [2:0]       prev_idx_q, prev_idx_d;
  logic [7:0]       prev_seg_q, prev_seg_d;
  logic             enable_error_q, enable_error_d;

  logic             digit_update_q, digit_update_d;
  logic             seg_error_q, seg_error_d;
  logic [2:0]       digit_index_q, digit_index_d;
  logic [5:0][3:0]  store_q, store_d;
  logic [5:0]       seen_q, seen_d;
  logic [5:0]       dp_q, dp_d;
  logic [23:0]      time_bcd_q, time_bcd_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_changed_q, frame_changed_d;

  logic             en_any;
  logic             en_one_hot;
  logic [2:0]       en_idx;
  logic             same_sample;
  logic [4:0]       glyph;

  // Returns {ok, bcd}; ok=0 for anything that is not a decimal digit.
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h7C: r = 5'h16;
      7'h07: r = 5'h17;
      7'h27: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h67: r = 5'h19;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    seg_s_d = SEG_ACTIVE_LOW ? ~seg_in : seg_in;
    en_s_d  = EN_ACTIVE_LOW ? ~enable_in : enable_in;
  end

  always_comb begin
    en_any     = |en_s_q;
    en_one_hot = en_any && ((en_s_q & (en_s_q - 6'd1)) == 6'd0);
    en_idx     = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (en_s_q[i]) en_idx = 3'(i);
    end
    same_sample = prev_valid_q && (en_idx == prev_idx_q) && (seg_s_q == prev_seg_q);
  end

  // Stability tracking; hit marks the single cycle the count first reaches STABLE.
  always_comb begin
    cnt_d          = 16'd0;
    hit_d          = 1'b0;
    prev_valid_d   = en_one_hot;
    prev_idx_d     = en_idx;
    prev_seg_d     = seg_s_q;
    enable_error_d = en_any && !en_one_hot;
    if (en_one_hot) begin
      if (same_sample) begin
        cnt_d = (cnt_q == STABLE) ? cnt_q : cnt_q + 16'd1;
      end else begin
        cnt_d = 16'd1;
      end
      hit_d = (cnt_d == STABLE) && !(same_sample && (cnt_q == STABLE));
    end
  end

  assign glyph = decode_glyph(prev_seg_q[6:0]);

  always_comb begin
    digit_update_d  = 1'b0;
    seg_error_d     = 1'b0;
    digit_index_d   = digit_index_q;
    store_d         = store_q;
    seen_d          = seen_q;
    dp_d            = dp_q;
    time_bcd_d      = time_bcd_q;
    frame_valid_d   = 1'b0;
    frame_changed_d = 1'b0;

    // Frame publish uses the store as it stood before any same-cycle write.
    if (seen_q == 6'h3F) begin
      time_bcd_d      = store_q;
      frame_valid_d   = 1'b1;
      frame_changed_d = (store_q != time_bcd_q);
      seen_d          = 6'h00;
    end

    if (hit_q) begin
      if (glyph[4]) begin
        digit_update_d = 1'b1;
        digit_index_d  = prev_idx_q;
        for (int i = 0; i < 6; i++) begin
          if (prev_idx_q == 3'(i)) begin
            store_d[i] = glyph[3:0];
            seen_d[i]  = 1'b1;
            dp_d[i]    = prev_seg_q[7];
          end
        end
      end else begin
        seg_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s_q         <= 8'd0;
      en_s_q          <= 6'd0;
      cnt_q           <= 16'd0;
      hit_q           <= 1'b0;
      prev_valid_q    <= 1'b0;
      prev_idx_q      <= 3'd0;
      prev_seg_q      <= 8'd0;
      enable_error_q  <= 1'b0;
      digit_update_q  <= 1'b0;
      seg_error_q     <= 1'b0;
      digit_index_q   <= 3'd0;
      store_q         <= '0;
      seen_q          <= 6'd0;
      dp_q            <= 6'd0;
      time_bcd_q      <= 24'd0;
      frame_valid_q   <= 1'b0;
      frame_changed_q <= 1'b0;
    end else begin
      seg_s_q         <= seg_s_d;
      en_s_q          <= en_s_d;
      cnt_q           <= cnt_d;
      hit_q           <= hit_d;
      prev_valid_q    <= prev_valid_d;
      prev_idx_q      <= prev_idx_d;
      prev_seg_q      <= prev_seg_d;
      enable_error_q  <= enable_error_d;
      digit_update_q  <= digit_update_d;
      seg_error_q     <= seg_error_d;
      digit_index_q   <= digit_index_d;
      store_q         <= store_d;
      seen_q          <= seen_d;
      dp_q            <= dp_d;
      time_bcd_q      <= time_bcd_d;
      frame_valid_q   <= frame_valid_d;
      frame_changed_q <= frame_changed_d;
    end
  end

  assign time_bcd      = time_bcd_q;
  assign frame_valid   = frame_valid_q;
  assign frame_changed = frame_changed_q;
  assign digit_update  = digit_update_q;
  assign digit_index   = digit_index_q;
  assign dp_flags      = dp_q;
  assign seg_error     = seg_error_q;
  assign enable_error  = enable_error_q;

endmodule

// File: tb/tb_seg_display_capture.sv
// Randomised and directed stimulus for seg_display_capture, checked cycle by cycle
// against a run-length / event-schedule reference model.
module tb_seg_display_capture;

  localparam int S    = 4;
  localparam int MAXC = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg_in = 8'hFF;
  logic [5:0]  enable_in = 6'h3F;
  logic [23:0] time_bcd;
  logic        frame_valid, frame_changed, digit_update, seg_error, enable_error;
  logic [2:0]  digit_index;
  logic [5:0]  dp_flags;

  seg_display_capture #(
    .STABLE_CYCLES(S),
    .SEG_ACTIVE_LOW(1'b1),
    .EN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .enable_in(enable_in),
    .time_bcd(time_bcd),
    .frame_valid(frame_valid),
    .frame_changed(frame_changed),
    .digit_update(digit_update),
    .digit_index(digit_index),
    .dp_flags(dp_flags),
    .seg_error(seg_error),
    .enable_error(enable_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] gly [10];
  logic [7:0] gly_alt [10];

  // Reference model: scheduled output events keyed by observation cycle.
  bit         acc_v [MAXC];
  logic [7:0] acc_seg [MAXC];
  int         acc_idx [MAXC];
  bit         err_v [MAXC];
  bit         frm_v [MAXC];
  int         run;
  bit         pv;
  int         pidx;
  logic [7:0] pseg;
  logic [3:0] m_store [6];
  logic [5:0] m_seen, m_dp;
  logic [23:0] m_time;
  bit         e_upd, e_serr, e_eerr, e_fv, e_fc;
  int         e_idx;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  function automatic logic [4:0] ref_glyph(input logic [6:0] s);
    for (int d = 0; d < 10; d++) begin
      if (s == gly[d][6:0] || ((d == 6 || d == 7 || d == 9) && s == gly_alt[d][6:0]))
        return {1'b1, 4'(d)};
    end
    return 5'h00;
  endfunction

  task automatic model_step(input logic [5:0] en, input logic [7:0] sg, input bit rst);
    bit fire;
    int idx;
    logic [4:0] g;
    logic [23:0] nt;
    fire = 0;
    e_upd = 0; e_serr = 0; e_eerr = 0; e_fv = 0; e_fc = 0;
    if (rst) begin
      for (int t = cyc; t < MAXC; t++) begin
        acc_v[t] = 0; err_v[t] = 0; frm_v[t] = 0;
      end
      run = 0; pv = 0; m_seen = 0; m_dp = 0; m_time = 0;
      for (int i = 0; i < 6; i++) m_store[i] = 4'd0;
    end else begin
      if ($countones(en) == 1) begin
        idx = 0;
        for (int i = 0; i < 6; i++) if (en[i]) idx = i;
        if (pv && idx == pidx && sg == pseg) begin
          if (run < S) begin
            run++;
            fire = (run == S);
          end
        end else begin
          run = 1;
          fire = (S == 1);
        end
        pv = 1; pidx = idx; pseg = sg;
        if (fire && cyc + 2 < MAXC) begin
          acc_v[cyc+2] = 1; acc_seg[cyc+2] = sg; acc_idx[cyc+2] = idx;
        end
      end else begin
        run = 0; pv = 0;
        if (en != 6'd0 && cyc + 1 < MAXC) err_v[cyc+1] = 1;
      end

      e_fv = frm_v[cyc];
      if (e_fv) begin
        nt = {m_store[5], m_store[4], m_store[3], m_store[2], m_store[1], m_store[0]};
        e_fc = (nt != m_time);
        m_time = nt;
        m_seen = 6'd0;
      end
      if (acc_v[cyc]) begin
        g = ref_glyph(acc_seg[cyc][6:0]);
        if (g[4]) begin
          e_upd = 1;
          e_idx = acc_idx[cyc];
          m_store[e_idx] = g[3:0];
          m_seen[e_idx] = 1'b1;
          m_dp[e_idx] = acc_seg[cyc][7];
          if (m_seen == 6'h3F && cyc + 1 < MAXC) frm_v[cyc+1] = 1;
        end else begin
          e_serr = 1;
        end
      end
      e_eerr = err_v[cyc];
    end
  endtask

  // One clock: drive active-high values as active-low pins, then model and compare.
  task automatic step(input logic [5:0] en_hi, input logic [7:0] seg_hi, input bit rst);
    @(negedge clk);
    rst_n = !rst;
    seg_in = ~seg_hi;
    enable_in = ~en_hi;
    @(posedge clk);
    #1;
    model_step(en_hi, seg_hi, rst);
    check_eq("pulses", {27'd0, digit_update, seg_error, enable_error, frame_valid, frame_changed},
             {27'd0, e_upd, e_serr, e_eerr, e_fv, e_fc});
    check_eq("time_bcd", {8'd0, time_bcd}, {8'd0, m_time});
    check_eq("dp_flags", {26'd0, dp_flags}, {26'd0, m_dp});
    if (e_upd) check_eq("digit_index", {29'd0, digit_index}, e_idx);
    if (rst) check_eq("rst_index", {29'd0, digit_index}, 32'd0);
    if (frame_valid) $display("frame cyc=%0d time=%06h changed=%0b", cyc, time_bcd, frame_changed);
    if (cyc < MAXC - 4) cyc++;
  endtask

  task automatic scan(input logic [23:0] t, input int dwell, input int gap,
                      input logic [5:0] dpm, input int ndig, input bit alt);
    logic [3:0] d;
    logic [7:0] sg;
    for (int k = 0; k < ndig; k++) begin
      d = t[4*k +: 4];
      sg = (d > 4'd9) ? 8'h00 : ((alt && (d == 6 || d == 7 || d == 9)) ? gly_alt[d] : gly[d]);
      sg[7] = dpm[k];
      repeat (dwell) step(6'd1 << k, sg, 1'b0);
      repeat (gap) step(6'd0, 8'($urandom), 1'b0);
    end
  endtask

  function automatic logic [23:0] rand_time();
    logic [23:0] r;
    for (int k = 0; k < 6; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    gly = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    gly_alt = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7C, 8'h27, 8'h7F, 8'h67};
    for (int t = 0; t < MAXC; t++) begin
      acc_v[t] = 0; err_v[t] = 0; frm_v[t] = 0; acc_seg[t] = 0; acc_idx[t] = 0;
    end

    repeat (3) step(6'd0, 8'd0, 1'b1);
    repeat (3) step(6'd0, 8'd0, 1'b0);

    scan(24'h123456, 8, 2, 6'd0, 6, 1'b0);
    scan(24'h123456, 8, 2, 6'd0, 6, 1'b0);
    scan(24'h123457, 8, 2, 6'd0, 6, 1'b0);

    repeat (3) step(6'b000010, gly[3], 1'b0);
    repeat (2) step(6'd0, 8'd0, 1'b0);
    repeat (200) step(6'b001000, gly[8], 1'b0);
    repeat (2) step(6'd0, 8'd0, 1'b0);

    repeat (5) step(6'b000011, gly[1], 1'b0);
    repeat (2) step(6'd0, 8'd0, 1'b0);
    repeat (6) step(6'b000001, 8'h49, 1'b0);
    repeat (6) step(6'b000100, 8'h00, 1'b0);
    repeat (2) step(6'd0, 8'd0, 1'b0);

    scan(24'h987654, 8, 2, 6'd0, 3, 1'b0);
    step(6'b000001, gly[4], 1'b1);
    scan(24'h987654, 8, 2, 6'd0, 6, 1'b0);

    scan(24'h679679, 6, 1, 6'b000100, 6, 1'b1);
    scan(24'h093959, 5, 0, 6'd0, 6, 1'b0);

    for (int n = 0; n < 40; n++) begin
      scan(rand_time(), $urandom_range(1, 9), $urandom_range(0, 2),
           6'($urandom), 6, 1'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        for (int j = 0; j < 20; j++) step(6'($urandom), 8'($urandom), 1'b0);
      end
      if ($urandom_range(0, 15) == 0) step(6'd0, 8'd0, 1'b1);
    end

    repeat (6) step(6'd0, 8'd0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
